// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with majority-vote sampling, error flags and an RX FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              rx_busy,
  output logic                              overrun,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              break_det,
  input  logic                              err_clr
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_FW       = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  SMP0    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  SMP1    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  DECIDE  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0]  WIN_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_DB = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_FW-1:0] FULL_N  = CNT_FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP1,
    S_STOP2,
    S_BREAK_WAIT
  } state_t;

  state_t state, state_nxt;

  logic                 rx_meta, rx_sync, rx_prev;
  logic                 smp0, smp1;
  logic                 maj;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop1_bit;

  logic                 dec, win_end;
  logic                 frame_end;
  logic                 push_req, brk_set, fe_set, pe_set;
  logic                 all_stop_zero, any_stop_zero, par_bad, is_break;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_FW-1:0]    count;
  logic                 full, push, pop, ovr_set;

  // Two-flop synchroniser for the asynchronous line, plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is the live value at DECIDE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else begin
      if (cnt == SMP0) smp0 <= rx_sync;
      if (cnt == SMP1) smp1 <= rx_sync;
    end
  end

  assign maj     = (smp0 & smp1) | (smp0 & rx_sync) | (smp1 & rx_sync);
  assign dec     = (cnt == DECIDE);
  assign win_end = (cnt == WIN_END);

  // End-of-frame classification terms; stop1_bit only matters for two-stop framing.
  assign all_stop_zero = !maj && ((STOP_BITS == 1) || !stop1_bit);
  assign any_stop_zero = !maj || ((STOP_BITS == 2) && !stop1_bit);
  assign par_bad       = (PARITY == 1) ? ((^shreg ^ par_bit) != 1'b1) :
                         (PARITY == 2) ? ((^shreg ^ par_bit) != 1'b0) : 1'b0;
  assign is_break      = (shreg == '0) && ((PARITY == 0) || !par_bit) && all_stop_zero;

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and end-of-frame event decoding.
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    push_req  = 1'b0;
    brk_set   = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) state_nxt = S_START;
      end
      S_START: begin
        if (dec && maj)   state_nxt = S_IDLE;
        else if (win_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (win_end && (bit_idx == LAST_DB))
          state_nxt = (PARITY != 0) ? S_PAR : S_STOP1;
      end
      S_PAR: begin
        if (win_end) state_nxt = S_STOP1;
      end
      S_STOP1: begin
        if (dec && (STOP_BITS == 1)) frame_end = 1'b1;
        else if (win_end)            state_nxt = S_STOP2;
      end
      S_STOP2: begin
        if (dec) frame_end = 1'b1;
      end
      S_BREAK_WAIT: begin
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Leaving at the stop decision (mid-bit) lets the next start edge resynchronise the frame.
    if (frame_end) begin
      if (is_break) begin
        brk_set   = 1'b1;
        state_nxt = S_BREAK_WAIT;
      end else begin
        state_nxt = S_IDLE;
        if (any_stop_zero) fe_set = 1'b1;
        else if (par_bad)  pe_set = 1'b1;
        else               push_req = 1'b1;
      end
    end
  end

  // Bit-window counter and frame datapath; the start-detect cycle counts as position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop1_bit <= 1'b0;
    end else if ((state == S_IDLE) || (state == S_BREAK_WAIT)) begin
      cnt     <= (state_nxt == S_START) ? CNT_W'(1) : '0;
      bit_idx <= '0;
    end else begin
      cnt <= win_end ? '0 : cnt + CNT_W'(1);
      if ((state == S_DATA) && dec)     shreg     <= {maj, shreg[DATA_BITS-1:1]};
      if ((state == S_DATA) && win_end) bit_idx   <= bit_idx + BIT_W'(1);
      if ((state == S_PAR) && dec)      par_bit   <= maj;
      if ((state == S_STOP1) && dec)    stop1_bit <= maj;
    end
  end

  assign full    = (count == FULL_N);
  assign pop     = rx_valid && rx_ready;
  assign push    = push_req && (!full || pop);
  assign ovr_set = push_req && full && !pop;

  // FIFO pointers and occupancy; a pop on a full FIFO frees the slot the push lands in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_FW'(1);
        2'b01:   count <= count - CNT_FW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, no reset needed since reads are gated by rx_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // Sticky error flags; a same-cycle set beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun    <= ovr_set | (overrun    & !err_clr);
      frame_err  <= fe_set  | (frame_err  & !err_clr);
      parity_err <= pe_set  | (parity_err & !err_clr);
      break_det  <= brk_set | (break_det  & !err_clr);
    end
  end

  assign rx_valid   = (count != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;
  assign rx_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 instance and 8E1 instance)
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BITNS = 320;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       rx_ready0 = 1'b0, rx_ready1 = 1'b0;
  logic       err_clr0 = 1'b0, err_clr1 = 1'b0;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic [4:0] fifo_count0, fifo_count1;
  logic       rx_busy0, rx_busy1;
  logic       overrun0, frame_err0, parity_err0, break_det0;
  logic       overrun1, frame_err1, parity_err1, break_det1;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         total_cnt = 0;
  int         pass_cnt  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ_HZ(100_000_000), .BAUD(3_125_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .fifo_count(fifo_count0), .rx_busy(rx_busy0), .overrun(overrun0),
    .frame_err(frame_err0), .parity_err(parity_err0), .break_det(break_det0), .err_clr(err_clr0));

  uart_rx_fifo #(.CLK_FREQ_HZ(100_000_000), .BAUD(3_125_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .fifo_count(fifo_count1), .rx_busy(rx_busy1), .overrun(overrun1),
    .frame_err(frame_err1), .parity_err(parity_err1), .break_det(break_det1), .err_clr(err_clr1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic send0(input logic [7:0] d, input logic stop_v);
    rx0 = 1'b0; #BITNS;
    for (int i = 0; i < 8; i++) begin rx0 = d[i]; #BITNS; end
    rx0 = stop_v; #BITNS;
    rx0 = 1'b1;
  endtask

  task automatic send1(input logic [7:0] d, input logic par);
    rx1 = 1'b0; #BITNS;
    for (int i = 0; i < 8; i++) begin rx1 = d[i]; #BITNS; end
    rx1 = par; #BITNS;
    rx1 = 1'b1; #BITNS;
  endtask

  task automatic pop0();
    @(posedge clk); #1 rx_ready0 = 1'b1;
    @(posedge clk); #1 rx_ready0 = 1'b0;
  endtask

  task automatic clr0();
    @(posedge clk); #1 err_clr0 = 1'b1;
    @(posedge clk); #1 err_clr0 = 1'b0;
  endtask

  // Data monitors: every pop the DUT performs is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rx_valid0 && rx_ready0) begin
      if (exp0.size() == 0) begin
        total_cnt++;
        $display("FAIL dut0_unexpected_pop: got 0x%0h, required no data", rx_data0);
      end else begin
        check("dut0_rx_data", 32'(rx_data0), 32'(exp0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rx_valid1 && rx_ready1) begin
      if (exp1.size() == 0) begin
        total_cnt++;
        $display("FAIL dut1_unexpected_pop: got 0x%0h, required no data", rx_data1);
      end else begin
        check("dut1_rx_data", 32'(rx_data1), 32'(exp1.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    #25;
    check("reset_outputs", 32'({rx_valid0, fifo_count0, rx_busy0, overrun0, frame_err0,
                                parity_err0, break_det0, rx_data0}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #200;

    // 1. single 0x55 8N1
    exp0.push_back(8'h55);
    send0(8'h55, 1'b1);
    @(negedge clk);
    check("t1_valid", 32'(rx_valid0), 32'd1);
    check("t1_count", 32'(fifo_count0), 32'd1);
    check("t1_flags", 32'({overrun0, frame_err0, parity_err0, break_det0}), 32'd0);
    pop0();
    @(negedge clk);
    check("t1_count_after_pop", 32'(fifo_count0), 32'd0);
    check("t1_valid_after_pop", 32'(rx_valid0), 32'd0);

    // 2. 17 bytes with no consumer: the last one overruns
    for (int b = 0; b <= 16; b++) begin
      if (b < 16) exp0.push_back(8'(b));
      send0(8'(b), 1'b1);
    end
    @(negedge clk);
    check("t2_count_full", 32'(fifo_count0), 32'd16);
    check("t2_overrun", 32'(overrun0), 32'd1);
    @(posedge clk); #1 rx_ready0 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!rx_valid0) break;
    end
    @(posedge clk); #1 rx_ready0 = 1'b0;
    check("t2_drained", 32'(rx_valid0), 32'd0);
    check("t2_queue_empty", 32'(exp0.size()), 32'd0);
    clr0();
    @(negedge clk);
    check("t2_overrun_cleared", 32'(overrun0), 32'd0);

    // 3. short low glitch is a false start
    rx0 = 1'b0; #50; rx0 = 1'b1;
    #1000;
    @(negedge clk);
    check("t3_busy", 32'(rx_busy0), 32'd0);
    check("t3_count", 32'(fifo_count0), 32'd0);
    check("t3_flags", 32'({overrun0, frame_err0, parity_err0, break_det0}), 32'd0);

    // 4. framing error then a good frame
    send0(8'hA5, 1'b0);
    #BITNS;
    @(negedge clk);
    check("t4_frame_err", 32'(frame_err0), 32'd1);
    check("t4_no_push", 32'(fifo_count0), 32'd0);
    check("t4_no_break", 32'(break_det0), 32'd0);
    clr0();
    @(negedge clk);
    check("t4_frame_err_cleared", 32'(frame_err0), 32'd0);
    exp0.push_back(8'h3C);
    send0(8'h3C, 1'b1);
    @(negedge clk);
    check("t4_count", 32'(fifo_count0), 32'd1);
    pop0();

    // 5. even parity instance: wrong then right parity for 0x07
    rx_ready1 = 1'b1;
    send1(8'h07, 1'b0);
    @(negedge clk);
    check("t5_parity_err", 32'(parity_err1), 32'd1);
    check("t5_no_push", 32'(fifo_count1), 32'd0);
    exp1.push_back(8'h07);
    send1(8'h07, 1'b1);
    #100;
    @(negedge clk);
    check("t5_queue_empty", 32'(exp1.size()), 32'd0);
    check("t5_frame_err", 32'(frame_err1), 32'd0);

    // 6. break, then reset mid-frame, then a clean byte
    rx0 = 1'b0;
    #(BITNS * 20);
    @(negedge clk);
    check("t6_break", 32'(break_det0), 32'd1);
    check("t6_busy_low", 32'(rx_busy0), 32'd1);
    check("t6_no_push", 32'(fifo_count0), 32'd0);
    rx0 = 1'b1;
    #200;
    @(negedge clk);
    check("t6_busy_released", 32'(rx_busy0), 32'd0);
    rx0 = 1'b0; #(BITNS * 3); rx0 = 1'b1; #(BITNS);
    check("t6_busy_midframe", 32'(rx_busy0), 32'd1);
    rst_n = 1'b0;
    #20;
    check("t6_reset_outputs", 32'({rx_valid0, fifo_count0, rx_busy0, overrun0, frame_err0,
                                   parity_err0, break_det0, rx_data0}), 32'd0);
    rx0 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    #400;
    exp0.push_back(8'h81);
    send0(8'h81, 1'b1);
    @(negedge clk);
    check("t6_count_81", 32'(fifo_count0), 32'd1);
    pop0();
    @(negedge clk);
    check("t6_final_queue0", 32'(exp0.size()), 32'd0);
    check("t6_final_flags", 32'({overrun0, frame_err0, parity_err0, break_det0}), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
